// File: rtl/psum_column_drain.sv
// psum_column_drain: drains one systolic-array column. Waits out the array
// fill latency, captures VecCount partial sums in order (optional ReLU) and
// buffers them in a first-word fall-through FIFO behind a valid/ready stream.
module psum_column_drain #(
  parameter int ACCUMULATOR_DATA_WIDTH = 32,
  parameter int LATENCY                = 8,
  parameter int COUNT_WIDTH            = 16,
  parameter int FIFO_DEPTH             = 8
) (
  input  logic                              CLK,
  input  logic                              ASYNC_RST,
  input  logic                              SYNC_RST,
  input  logic                              EN,
  input  logic                              START,
  input  logic [COUNT_WIDTH-1:0]            VecCount,
  input  logic                              ReluEn,
  input  logic [ACCUMULATOR_DATA_WIDTH-1:0] PsumIn,
  output logic [ACCUMULATOR_DATA_WIDTH-1:0] DataOut,
  output logic                              Valid,
  input  logic                              Ready,
  output logic                              Busy,
  output logic                              Done,
  output logic                              Overflow
);
  localparam int W  = ACCUMULATOR_DATA_WIDTH;
  localparam int CW = COUNT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt, cap_cnt, vec_q;
  logic            relu_q;
  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, push, pop, push_ok;
  logic [W-1:0]    psum_cap;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = (state == S_CAPTURE) && EN && !SYNC_RST;
  assign pop      = Valid && Ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok  = push && (!full || pop);
  assign psum_cap = (relu_q && PsumIn[W-1]) ? '0 : PsumIn;

  assign Valid    = !empty;
  assign DataOut  = Valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign Busy     = (state == S_WAIT) || (state == S_CAPTURE);
  assign Done     = (state == S_DONE);

  // Control FSM: fill-latency countdown, capture counting, one-cycle done.
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      cap_cnt  <= '0;
      vec_q    <= '0;
      relu_q   <= 1'b0;
    end else if (SYNC_RST) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      cap_cnt  <= '0;
      vec_q    <= '0;
      relu_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (START && EN) begin
          vec_q    <= VecCount;
          relu_q   <= ReluEn;
          wait_cnt <= LAT_M1;
          cap_cnt  <= '0;
          // With LATENCY=1 the START edge is already edge LATENCY-1.
          if (VecCount == '0)  state <= S_DONE;
          else if (LATENCY == 1) state <= S_CAPTURE;
          else                 state <= S_WAIT;
        end
        S_WAIT: if (EN) begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CW'(1)) state <= S_CAPTURE;
        end
        S_CAPTURE: if (EN) begin
          // Count advances even when the push is dropped on overflow.
          cap_cnt <= cap_cnt + 1'b1;
          if (cap_cnt == vec_q - 1'b1) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Overflow <= 1'b0;
    end else if (SYNC_RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) Overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are masked by Valid so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= psum_cap;
  end

endmodule
